// File: rtl/nibble_chain_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_chain_counter_pkg
// Purpose  : Shared constants and types for the nibble chain counter:
//            nibble width and the snapshot buffer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nibble_chain_counter_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    SNAP_EMPTY = 1'b0,
    SNAP_FULL  = 1'b1
  } snap_state_e;

endpackage : nibble_chain_counter_pkg
`default_nettype wire

// File: rtl/nibble_chain_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_chain_counter_if
// Purpose  : Control, count and snapshot-handshake bundle of the counter.
// Ports    : clear/load/load_val/en       - count control (master -> slave)
//            count/tc/wrap                - count status  (slave -> master)
//            snap_req/snap_ready          - snapshot handshake (master -> slave)
//            snap_valid/snap_data/snap_drop - snapshot buffer (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_chain_counter_if #(
  parameter int WIDTH = 16
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             snap_req;
  logic             snap_valid;
  logic [WIDTH-1:0] snap_data;
  logic             snap_ready;
  logic             snap_drop;

  modport master (
    output clear, load, load_val, en, snap_req, snap_ready,
    input  count, tc, wrap, snap_valid, snap_data, snap_drop
  );

  modport slave (
    input  clear, load, load_val, en, snap_req, snap_ready,
    output count, tc, wrap, snap_valid, snap_data, snap_drop
  );

endinterface : nibble_chain_counter_if
`default_nettype wire

// File: rtl/nibble_chain_counter_nibble_inc.sv
`default_nettype none
// ============================================================================
// Module   : nibble_inc
// Purpose  : 4-bit conditional incrementer. Each sum bit flips when the
//            carry-in and every lower bit of the value are set, so no bit
//            waits on another sum bit.
// Ports    : value    in  4  current nibble
//            cin      in  1  increment this nibble
//            sum      out 4  value + cin (mod 16)
//            cout     out 1  cin AND value == 4'hF
//            all_ones out 1  value == 4'hF
// Revision : 1.0 - initial release
// ============================================================================
module nibble_inc
  import nibble_chain_counter_pkg::*;
(
  input  wire logic [NIBBLE_W-1:0] value,
  input  wire logic                cin,
  output      logic [NIBBLE_W-1:0] sum,
  output      logic                cout,
  output      logic                all_ones
);

  logic [NIBBLE_W-1:0] w_toggle;

  // Prefix-AND of the carry-in with the lower value bits.
  assign w_toggle = {cin & (&value[2:0]), cin & (&value[1:0]), cin & value[0], cin};
  assign sum      = value ^ w_toggle;
  assign all_ones = &value;
  assign cout     = cin & all_ones;

endmodule : nibble_inc
`default_nettype wire

// File: rtl/nibble_chain_counter.sv
`default_nettype none
// ============================================================================
// Module   : nibble_chain_counter
// Purpose  : Up-counter built from a chain of 4-bit increment stages, with
//            clear / load / enable, terminal-count and wrap flags, and a
//            one-entry snapshot buffer with valid/ready handshake.
// Ports    : clk  in  rising-edge clock
//            rst  in  synchronous active-high reset
//            bus  nibble_chain_counter_if.slave (control, count, snapshot)
// Revision : 1.0 - initial release
// ============================================================================
module nibble_chain_counter
  import nibble_chain_counter_pkg::*;
#(
  parameter int                     NIBBLES   = 4,
  parameter logic [4*NIBBLES-1:0]   RESET_VAL = '0
) (
  input wire logic              clk,
  input wire logic              rst,
  nibble_chain_counter_if.slave bus
);

  localparam int WIDTH = NIBBLE_W * NIBBLES;

  logic [WIDTH-1:0]   count_q, count_d;
  logic               wrap_q, wrap_d;
  snap_state_e        state_q, state_d;
  logic [WIDTH-1:0]   snap_data_q, snap_data_d;
  logic               snap_drop_q, snap_drop_d;

  logic [WIDTH-1:0]   w_sum;
  logic [NIBBLES:0]   w_carry;
  logic [NIBBLES-1:0] w_all_ones;

  // Carry into nibble k is en AND all lower nibbles all-ones, taken from the
  // registered count rather than from any stage's sum.
  assign w_carry[0] = bus.en;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_nibble
    nibble_inc u_inc (
      .value    (count_q[k*NIBBLE_W +: NIBBLE_W]),
      .cin      (w_carry[k]),
      .sum      (w_sum[k*NIBBLE_W +: NIBBLE_W]),
      .cout     (w_carry[k+1]),
      .all_ones (w_all_ones[k])
    );
  end

  always_comb begin
    count_d     = count_q;
    wrap_d      = 1'b0;
    state_d     = state_q;
    snap_data_d = snap_data_q;
    snap_drop_d = snap_drop_q;

    if (bus.clear) begin
      count_d = RESET_VAL;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      count_d = w_sum;
      // Top carry-out means every nibble was F: this increment wraps to 0.
      wrap_d  = w_carry[NIBBLES];
    end

    // Snapshots always capture the pre-edge count.
    case (state_q)
      SNAP_EMPTY: begin
        if (bus.snap_req) begin
          snap_data_d = count_q;
          state_d     = SNAP_FULL;
        end
      end
      SNAP_FULL: begin
        if (bus.snap_ready) begin
          if (bus.snap_req) begin
            snap_data_d = count_q;
          end else begin
            state_d = SNAP_EMPTY;
          end
        end else if (bus.snap_req) begin
          snap_drop_d = 1'b1;
        end
      end
      default: state_d = SNAP_EMPTY;
    endcase

    if (bus.clear) begin
      snap_drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= RESET_VAL;
      wrap_q      <= 1'b0;
      state_q     <= SNAP_EMPTY;
      snap_data_q <= '0;
      snap_drop_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
      snap_drop_q <= snap_drop_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = &w_all_ones;
  assign bus.wrap       = wrap_q;
  assign bus.snap_valid = (state_q == SNAP_FULL);
  assign bus.snap_data  = snap_data_q;
  assign bus.snap_drop  = snap_drop_q;

endmodule : nibble_chain_counter
`default_nettype wire

// File: tb/tb_nibble_chain_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_chain_counter
// Purpose  : Directed bench for nibble_chain_counter. Each stimulus cycle
//            pushes its hand-computed post-edge expectation into a queue;
//            a monitor pops one entry after every rising edge and compares.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_chain_counter;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  nibble_chain_counter_if #(.WIDTH(WIDTH)) bus ();

  nibble_chain_counter #(.NIBBLES(4), .RESET_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus plus the expected state after that edge.
  task automatic step(input logic r, input logic clr, input logic ld, input logic [WIDTH-1:0] lv,
                      input logic e, input logic req, input logic rdy,
                      input logic [WIDTH-1:0] ecount, input logic ewrap, input logic evalid,
                      input logic [WIDTH-1:0] edata, input logic edrop);
    exp_t x;
    @(negedge clk);
    rst            = r;
    bus.clear      = clr;
    bus.load       = ld;
    bus.load_val   = lv;
    bus.en         = e;
    bus.snap_req   = req;
    bus.snap_ready = rdy;
    x.count = ecount;
    x.tc    = (ecount == 16'hFFFF);
    x.wrap  = ewrap;
    x.valid = evalid;
    x.data  = edata;
    x.drop  = edrop;
    exp_q.push_back(x);
  endtask

  // Monitor: compare after every edge for which an expectation exists.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count",      32'(bus.count),      32'(x.count));
        chk("tc",         32'(bus.tc),         32'(x.tc));
        chk("wrap",       32'(bus.wrap),       32'(x.wrap));
        chk("snap_valid", 32'(bus.snap_valid), 32'(x.valid));
        chk("snap_data",  32'(bus.snap_data),  32'(x.data));
        chk("snap_drop",  32'(bus.snap_drop),  32'(x.drop));
      end
    end
  end

  initial begin
    bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.en = 0;
    bus.snap_req = 0; bus.snap_ready = 0;

    //        rst clr ld lv        en req rdy  count    wrap val data     drop
    step(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    for (int i = 1; i <= 20; i++)
      step(0, 0, 0, 16'h0000, 1, 0, 0, 16'(i), 0, 0, 16'h0000, 0);

    // Nibble carry across 0x00FF.
    step(0, 0, 1, 16'h00FE, 0, 0, 0, 16'h00FE, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h00FF, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0100, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0101, 0, 0, 16'h0000, 0);

    // Terminal count, wrap pulse, then tc held while en=0.
    step(0, 0, 1, 16'hFFFE, 0, 0, 0, 16'hFFFE, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 0, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0001, 0, 0, 16'h0000, 0);

    // Loading 0 from all ones is not a wrap.
    step(0, 0, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 0);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

    // Priority: load over en, clear over load.
    step(0, 0, 1, 16'h1234, 1, 0, 0, 16'h1234, 0, 0, 16'h0000, 0);
    step(0, 1, 1, 16'h5555, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

    // Capture, drop while full, drain; ready while empty does nothing.
    step(0, 0, 1, 16'h0042, 0, 0, 0, 16'h0042, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0042, 0, 1, 16'h0042, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0043, 0, 1, 16'h0042, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0044, 0, 1, 16'h0042, 0);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0045, 0, 1, 16'h0042, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0045, 0, 1, 16'h0042, 1);
    step(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0045, 0, 0, 16'h0042, 1);
    step(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0045, 0, 0, 16'h0042, 1);

    // Pre-edge capture while counting, then accept-and-refill.
    step(0, 0, 1, 16'h004F, 0, 0, 0, 16'h004F, 0, 0, 16'h0042, 1);
    step(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0050, 0, 1, 16'h004F, 1);
    step(0, 0, 0, 16'h0000, 1, 1, 1, 16'h0051, 0, 1, 16'h0050, 1);

    // Clear resets count and drop but leaves the buffer alone.
    step(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 16'h0050, 0);
    step(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0050, 1);
    step(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0001, 0, 1, 16'h0050, 1);

    // Reset mid-stream with a pending request: everything back to reset.
    step(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nibble_chain_counter
`default_nettype wire
